// File: rtl/res_port_arbiter_if.sv
// Request/response and RAM-side signal bundle for res_port_arbiter.
// slave is the arbiter's view; master is the view of the engines and RAM around it.
interface res_port_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int AW    = 14,
    parameter int DW    = 8
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    req_we;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;
    logic                busy;
    logic                res_rd;
    logic                res_wr;
    logic [AW-1:0]       res_addr;
    logic [DW-1:0]       res_do;
    logic [DW-1:0]       res_di;

    modport slave (
        input  req, req_we, req_addr, req_wdata, res_di,
        output gnt, rvalid, rdata, busy, res_rd, res_wr, res_addr, res_do
    );

    modport master (
        output req, req_we, req_addr, req_wdata, res_di,
        input  gnt, rvalid, rdata, busy, res_rd, res_wr, res_addr, res_do
    );
endinterface

// File: rtl/res_port_arbiter.sv
// Shares the single-port result RAM among the distance-transform engines.
// Define ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module res_port_arbiter #(
    parameter int N_REQ  = 3,
    parameter int AW     = 14,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    res_port_arbiter_if.slave bus
);
    localparam int IDW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    logic [IDW-1:0]   gnt_id;
    logic             gnt_any;
    logic [N_REQ-1:0] gnt;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;

    logic             res_rd_q, res_wr_q;
    logic [AW-1:0]    res_addr_q;
    logic [DW-1:0]    res_do_q;
    logic [RD_LAT:0]  tag_vld_q;
    logic [IDW-1:0]   tag_id_q [RD_LAT+1];
    logic [N_REQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q;

`ifdef ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    function automatic int rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return (s >= N_REQ) ? s - N_REQ : s;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && bus.req[rr_idx(ptr_q, k)]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(rr_idx(ptr_q, k));
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    // Scanning downwards lets the lowest requesting index overwrite the others.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        gnt = '0;
        if (gnt_any) gnt[gnt_id] = 1'b1;
    end

    assign sel_we    = bus.req_we[gnt_id];
    assign sel_addr  = bus.req_addr[gnt_id*AW +: AW];
    assign sel_wdata = bus.req_wdata[gnt_id*DW +: DW];

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_rd_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
        end else begin
            res_rd_q <= gnt_any && !sel_we;
            res_wr_q <= gnt_any && sel_we;
            if (gnt_any)           res_addr_q <= sel_addr;
            if (gnt_any && sel_we) res_do_q   <= sel_wdata;
        end
    end

    // NOTE: the tag pipeline is reset entry by entry so a reset drops every read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld_q <= '0;
            for (int s = 0; s <= RD_LAT; s++) tag_id_q[s] <= '0;
        end else begin
            tag_vld_q[0] <= gnt_any && !sel_we;
            tag_id_q[0]  <= gnt_id;
            for (int s = 1; s <= RD_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    always_comb begin
        rvalid_d = '0;
        if (tag_vld_q[RD_LAT]) rvalid_d[tag_id_q[RD_LAT]] = 1'b1;
    end

    // The last tag stage lines up with the cycle res_di is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            if (tag_vld_q[RD_LAT]) rdata_q <= bus.res_di;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = |tag_vld_q;
    assign bus.res_rd   = res_rd_q;
    assign bus.res_wr   = res_wr_q;
    assign bus.res_addr = res_addr_q;
    assign bus.res_do   = res_do_q;
endmodule

// File: tb/tb_res_port_arbiter.sv
// Scoreboard bench for res_port_arbiter: requesters, a RAM model and a behavioural reference.
// Honours ARB_RR_EN the same way as the design.
module tb_res_port_arbiter;
    localparam int N_REQ  = 3;
    localparam int AW     = 14;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;

    typedef struct { bit we; bit [AW-1:0] addr; bit [DW-1:0] wdata; int idle; } cmd_t;
    typedef struct { int due; bit we; bit [AW-1:0] addr; bit [DW-1:0] dout; } iss_t;
    typedef struct { int due; int id; bit [DW-1:0] data; } ret_t;
    typedef struct { int cyc; int id; } glog_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    res_port_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

    res_port_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // RAM model: RD_LAT-cycle read pipeline, plus a backdoor port for preloading
    bit [DW-1:0]   ram [1<<AW];
    logic [DW-1:0] lat_q [RD_LAT];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (bus.res_wr)  ram[bus.res_addr] <= bus.res_do;
        else if (bd_we)  ram[bd_addr] <= bd_data;
        lat_q[0] <= bus.res_rd ? ram[bus.res_addr] : '0;
        for (int s = 1; s < RD_LAT; s++) lat_q[s] <= lat_q[s-1];
    end
    assign bus.res_di = lat_q[RD_LAT-1];

    // Reference model state
    bit [DW-1:0]      ref_mem [1<<AW];
    int               ptr = 0;
    bit [DW-1:0]      last_do = '0;
    iss_t             iss_q [$];
    ret_t             ret_q [$];
    logic [N_REQ-1:0] acc = '0;
    bit               log_en = 1'b0;
    glog_t            glog [$];
    logic [DW-1:0]    last_rdata = '0;

    function automatic int model_pick(input logic [N_REQ-1:0] r);
`ifdef ARB_RR_EN
        for (int k = 0; k < N_REQ; k++)
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
`else
        for (int k = 0; k < N_REQ; k++)
            if (r[k]) return k;
`endif
        return -1;
    endfunction

    always @(negedge clk) begin
        int               gid;
        int               gi;
        logic [N_REQ-1:0] exp_gnt;
        bit               exp_busy;
        bit               w;
        bit [AW-1:0]      a;
        bit [DW-1:0]      d;
        iss_t             e;
        ret_t             r;
        if (!reset) begin
            iss_q.delete();
            ret_q.delete();
            ptr     = 0;
            last_do = '0;
            acc     = '0;
            check("rst_res_rd",   bus.res_rd,   0);
            check("rst_res_wr",   bus.res_wr,   0);
            check("rst_res_addr", bus.res_addr, 0);
            check("rst_res_do",   bus.res_do,   0);
            check("rst_rvalid",   bus.rvalid,   0);
            check("rst_rdata",    bus.rdata,    0);
            check("rst_busy",     bus.busy,     0);
        end else begin
            gid     = model_pick(bus.req);
            exp_gnt = (gid >= 0) ? N_REQ'(1 << gid) : '0;
            check("gnt", bus.gnt, exp_gnt);
            if (log_en && bus.gnt != '0) begin
                gi = -1;
                for (int i = 0; i < N_REQ; i++) if (bus.gnt[i]) gi = i;
                glog.push_back('{cyc, gi});
            end

            if (bus.res_rd || bus.res_wr) begin
                if (iss_q.size() == 0) begin
                    check("res_spurious", {bus.res_wr, bus.res_rd}, 0);
                end else begin
                    e = iss_q.pop_front();
                    check("iss_cycle", cyc, e.due);
                    check("res_wr",   bus.res_wr,   e.we);
                    check("res_rd",   bus.res_rd,   !e.we);
                    check("res_addr", bus.res_addr, e.addr);
                    check("res_do",   bus.res_do,   e.dout);
                end
            end else if (iss_q.size() > 0 && iss_q[0].due <= cyc) begin
                e = iss_q.pop_front();
                check("iss_missing", {bus.res_wr, bus.res_rd}, e.we ? 2 : 1);
            end

            if (bus.rvalid != '0) begin
                if (ret_q.size() == 0) begin
                    check("rvalid_spurious", bus.rvalid, 0);
                end else begin
                    r = ret_q.pop_front();
                    check("ret_cycle", cyc, r.due);
                    check("rvalid", bus.rvalid, 1 << r.id);
                    check("rdata", bus.rdata, r.data);
                    last_rdata = bus.rdata;
                end
            end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                r = ret_q.pop_front();
                check("ret_missing", bus.rvalid, 1 << r.id);
            end

            // a read granted in t keeps busy high from t+1 to t+1+RD_LAT
            exp_busy = 1'b0;
            foreach (ret_q[k])
                if (ret_q[k].due >= cyc + 1 && ret_q[k].due <= cyc + 1 + RD_LAT) exp_busy = 1'b1;
            check("busy", bus.busy, exp_busy);

            acc = exp_gnt;
            if (gid >= 0) begin
                w = bus.req_we[gid];
                a = bus.req_addr[gid*AW +: AW];
                d = bus.req_wdata[gid*DW +: DW];
                if (w) begin
                    last_do    = d;
                    ref_mem[a] = d;
                end
                iss_q.push_back('{cyc + 1, w, a, last_do});
                if (!w) ret_q.push_back('{cyc + 2 + RD_LAT, gid, ref_mem[a]});
`ifdef ARB_RR_EN
                ptr = (gid + 1) % N_REQ;
`endif
            end
        end
    end

    // Requesters: each holds its request until the reference model accepts it
    cmd_t cmd_q [N_REQ][$];
    cmd_t cur [N_REQ];
    bit   pres [N_REQ];
    bit   loaded [N_REQ];
    int   wcnt [N_REQ];

    initial begin
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc[i]) pres[i] = 1'b0;
                if (!reset) begin
                    pres[i]   = 1'b0;
                    loaded[i] = 1'b0;
                end
                if (!pres[i] && !loaded[i] && cmd_q[i].size() > 0) begin
                    cur[i]    = cmd_q[i].pop_front();
                    wcnt[i]   = cur[i].idle;
                    loaded[i] = 1'b1;
                end
                if (loaded[i]) begin
                    if (wcnt[i] == 0) begin
                        pres[i]   = 1'b1;
                        loaded[i] = 1'b0;
                    end else begin
                        wcnt[i]--;
                    end
                end
                bus.req[i]                = pres[i];
                bus.req_we[i]             = cur[i].we;
                bus.req_addr[i*AW +: AW]  = cur[i].addr;
                bus.req_wdata[i*DW +: DW] = cur[i].wdata;
            end
        end
    end

    task automatic push(input int id, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int idle);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d; c.idle = idle;
        cmd_q[id].push_back(c);
    endtask

    function automatic bit all_idle();
        bit idle = (iss_q.size() == 0) && (ret_q.size() == 0);
        for (int i = 0; i < N_REQ; i++)
            if (cmd_q[i].size() > 0 || pres[i] || loaded[i]) idle = 1'b0;
        return idle;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        @(negedge clk);
        while (!all_idle() && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", all_idle(), 1);
        repeat (RD_LAT + 3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic check_order(input string name, input int e [6], input int n);
        check({name, "_len"}, glog.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < glog.size()) begin
                check({name, "_id"}, glog[k].id, e[k]);
                if (k > 0) check({name, "_b2b"}, glog[k].cyc - glog[k-1].cyc, 1);
            end
        end
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int e6 [6];
        int n;
        reset = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        push(0, 1'b1, 14'h0010, 8'h01, 0);
        drain(50);

        @(posedge clk);
        #2 bd_we = 1'b1; bd_addr = 14'h3FFF; bd_data = 8'h05;
        ref_mem[14'h3FFF] = 8'h05;
        @(posedge clk);
        #2 bd_we = 1'b0;
        push(2, 1'b0, 14'h3FFF, 8'h00, 0);
        drain(50);
        check("read_3fff_data", last_rdata, 8'h05);

        glog.delete();
        log_en = 1'b1;
        push(1, 1'b1, 14'h0100, 8'h07, 0);
        push(1, 1'b0, 14'h0100, 8'h00, 0);
        drain(50);
        log_en = 1'b0;
        e6 = '{1, 1, 0, 0, 0, 0};
        check_order("wr_rd", e6, 2);
        check("wr_rd_data", last_rdata, 8'h07);

        push(1, 1'b0, 14'h0081, 8'h00, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!acc[1] && n < 20);
        check("rst_mid_granted", acc[1], 1);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (8) @(negedge clk);

        do_reset();
        glog.delete();
        log_en = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_REQ; i++) push(i, 1'b1, AW'(16 + i), DW'(r * 8 + i), 0);
        drain(100);
        log_en = 1'b0;
`ifdef ARB_RR_EN
        e6 = '{0, 1, 2, 0, 1, 2};
`else
        e6 = '{0, 0, 1, 1, 2, 2};
`endif
        check_order("req111", e6, 6);

        do_reset();
        glog.delete();
        log_en = 1'b1;
        for (int r = 0; r < 3; r++) push(1, 1'b0, AW'(16 + r), 8'h00, 0);
        for (int r = 0; r < 2; r++) push(2, 1'b0, AW'(18 + r), 8'h00, 0);
        drain(100);
        log_en = 1'b0;
`ifdef ARB_RR_EN
        e6 = '{1, 2, 1, 2, 1, 0};
`else
        e6 = '{1, 1, 1, 2, 2, 0};
`endif
        check_order("req110", e6, 5);

        for (int k = 0; k < 150; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                push(i, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)),
                     DW'($urandom),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        end
        drain(5000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
